uart_tx_frame_arbiter: RTL and testbench

//  Shares one SERIAL_TX_FIFO write port between N_REQ scoreboard requesters (score, timer, status, ...).

---
 rtl/uart_tx_frame_arbiter_pkg.sv | 24 ++
 rtl/uart_tx_frame_arbiter_rr_arbiter.sv | 33 +++
 rtl/uart_tx_frame_arbiter.sv | 109 ++++++++++
 tb/tb_uart_tx_frame_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_arbiter_pkg.sv
// Shared definitions for the UART TX frame arbiter: frame layout, FSM encoding and checksum.
package uart_tx_frame_arbiter_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN      = 5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_ID   = 3'd2;
    localparam state_t ST_PH   = 3'd3;
    localparam state_t ST_PL   = 3'd4;
    localparam state_t ST_CS   = 3'd5;
    localparam state_t ST_GAP  = 3'd6;

    function automatic logic [7:0] frame_csum(input logic [7:0] hdr,
                                              input logic [7:0] id,
                                              input logic [7:0] ph,
                                              input logic [7:0] pl);
        return hdr ^ id ^ ph ^ pl;
    endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N-1 -> 0.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid && req[j]) begin
                valid  = 1'b1;
                idx    = IW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that serialises one granted requester at a time into a 5-byte frame
// (HEADER, ID, PAY_HI, PAY_LO, CSUM) onto a FIFO write port, honouring FIFO_FULL per byte.
module uart_tx_frame_arbiter
    import uart_tx_frame_arbiter_pkg::*;
#(
    parameter int         N_REQ      = 4,
    parameter logic [7:0] HEADER     = HEADER_DEFAULT,
    parameter int         GAP_CYCLES = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     REQ,
    input  logic [16*N_REQ-1:0]  PAYLOAD,
    output logic [N_REQ-1:0]     GNT,
    input  logic                 FIFO_FULL,
    output logic                 WR_EN,
    output logic [7:0]           DATA,
    output logic                 BUSY
);

    localparam int IW = $clog2(N_REQ);

    state_t           state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    id_q;
    logic [15:0]      pay_q;
    logic [7:0]       gap_cnt;
    logic [N_REQ-1:0] gnt_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic             byte_state;
    logic [7:0]       id_byte;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (REQ),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign id_byte    = {{(8-IW){1'b0}}, id_q};
    assign byte_state = (state >= ST_HDR) && (state <= ST_CS);
    // A byte is consumed on every edge where WR_EN is high; FIFO_FULL just freezes the FSM.
    assign WR_EN      = byte_state & ~FIFO_FULL;
    assign BUSY       = (state != ST_IDLE);
    assign GNT        = gnt_q;

    always_comb begin
        DATA = '0;
        case (state)
            ST_HDR:  DATA = HEADER;
            ST_ID:   DATA = id_byte;
            ST_PH:   DATA = pay_q[15:8];
            ST_PL:   DATA = pay_q[7:0];
            ST_CS:   DATA = frame_csum(HEADER, id_byte, pay_q[15:8], pay_q[7:0]);
            default: DATA = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            pay_q   <= '0;
            gap_cnt <= '0;
            gnt_q   <= '0;
        end else begin
            gnt_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt_q  <= arb_gnt;
                        id_q   <= arb_idx;
                        pay_q  <= PAYLOAD[16*arb_idx +: 16];
                        rr_ptr <= (arb_idx == IW'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
                        state  <= ST_HDR;
                    end
                end
                ST_HDR: if (WR_EN) state <= ST_ID;
                ST_ID:  if (WR_EN) state <= ST_PH;
                ST_PH:  if (WR_EN) state <= ST_PL;
                ST_PL:  if (WR_EN) state <= ST_CS;
                ST_CS: begin
                    if (WR_EN) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= 8'(GAP_CYCLES - 1);
                            state   <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Bench for uart_tx_frame_arbiter: table vectors, directed corner sequences and a random scoreboard run.
module tb_uart_tx_frame_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N-1:0]     req, gnt;
    logic [16*N-1:0]  payload;
    logic             full, wr_en, busy;
    logic [7:0]       data;

    logic [N-1:0]     req2, gnt2;
    logic [16*N-1:0]  payload2;
    logic             full2, wr2, busy2;
    logic [7:0]       data2;

    uart_tx_frame_arbiter #(.N_REQ(N), .HEADER(8'hA5), .GAP_CYCLES(0)) dut (
        .CLK(clk), .RST(rst_n), .REQ(req), .PAYLOAD(payload), .GNT(gnt),
        .FIFO_FULL(full), .WR_EN(wr_en), .DATA(data), .BUSY(busy)
    );

    uart_tx_frame_arbiter #(.N_REQ(N), .HEADER(8'hA5), .GAP_CYCLES(3)) dut_gap (
        .CLK(clk), .RST(rst_n), .REQ(req2), .PAYLOAD(payload2), .GNT(gnt2),
        .FIFO_FULL(full2), .WR_EN(wr2), .DATA(data2), .BUSY(busy2)
    );

    typedef struct {
        int          id;
        logic [15:0] pay;
        logic [N-1:0] gnt;
        logic [39:0] frame;
    } vec_t;

    vec_t tbl[5];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_frames = 0;

    logic [N-1:0]    drop_mask;
    bit              rand_mode;

    // reference model state
    int              ptr_m;
    logic [N-1:0]    prev_req;
    logic [16*N-1:0] prev_pay;
    logic [7:0]      byte_q[$];
    logic [23:0]     exp_q[$];
    logic [39:0]     frame_log[$];
    int              gnt_log[$];
    int              hdr_cyc[$];
    int              m_gi;
    logic [23:0]     m_e;
    logic [39:0]     m_got, m_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_expect(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard for the GAP_CYCLES=0 instance
    always @(negedge clk) begin
        if (!rst_n) begin
            byte_q.delete();
            exp_q.delete();
            ptr_m    = 0;
            prev_req = '0;
            prev_pay = '0;
        end else begin
            if (gnt != '0) begin
                m_gi = 0;
                for (int i = N - 1; i >= 0; i--) if (gnt[i]) m_gi = i;
                check("gnt_onehot", $countones(gnt), 1);
                check("gnt_rr_order", m_gi, rr_expect(prev_req, ptr_m));
                ptr_m = (m_gi + 1) % N;
                exp_q.push_back({8'(m_gi), prev_pay[16*m_gi +: 16]});
                gnt_log.push_back(m_gi);
            end
            if (wr_en) begin
                if (byte_q.size() == 0) hdr_cyc.push_back(cyc);
                byte_q.push_back(data);
                if (byte_q.size() == 5) begin
                    m_got = {byte_q[0], byte_q[1], byte_q[2], byte_q[3], byte_q[4]};
                    n_frames++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_without_grant: got %0h expected no frame", m_got);
                    end else begin
                        m_e   = exp_q.pop_front();
                        m_exp = {8'hA5, m_e[23:16], m_e[15:8], m_e[7:0],
                                 8'hA5 ^ m_e[23:16] ^ m_e[15:8] ^ m_e[7:0]};
                        check("frame_bytes", m_got, m_exp);
                    end
                    frame_log.push_back(m_got);
                    byte_q.delete();
                end
            end
            prev_req = req;
            prev_pay = payload;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req  = req & ~(gnt & drop_mask);
        req2 = req2 & ~gnt2;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    payload[16*i +: 16] = 16'($urandom);
                end
            end
            full = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((busy || req != '0) && n < bound) begin
            tick();
            n++;
        end
        check(name, {busy, |req}, 2'b00);
    endtask

    task automatic wait_log(input string name, input int cnt, input int bound);
        int n = 0;
        while (gnt_log.size() < cnt && n < bound) begin
            tick();
            n++;
        end
        check(name, gnt_log.size() >= cnt, 1);
    endtask

    task automatic collect2(output logic [39:0] f, output int first_wait);
        int got = 0;
        int n   = 0;
        f = '0;
        first_wait = 0;
        while (got < 5 && n < 50) begin
            @(negedge clk);
            n++;
            if (wr2) begin
                if (got == 0) first_wait = n;
                f = {f[31:0], data2};
                got++;
            end
        end
        check("gap_collect_bytes", got, 5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] fa, fb;
        int          w;

        tbl[0] = '{0, 16'h1234, 4'b0001, 40'hA500123483};
        tbl[1] = '{1, 16'hABCD, 4'b0010, 40'hA501ABCDC2};
        tbl[2] = '{2, 16'h0000, 4'b0100, 40'hA5020000A7};
        tbl[3] = '{3, 16'hFFFF, 4'b1000, 40'hA503FFFFA6};
        tbl[4] = '{2, 16'h5A5A, 4'b0100, 40'hA5025A5AA7};

        rst_n = 1'b0; req = '0; req2 = '0; payload = '0; payload2 = '0;
        full = 1'b0; full2 = 1'b0; drop_mask = '1; rand_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_data", data, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_data", data, 0);

        // single-requester frames from the table
        frame_log.delete();
        for (int v = 0; v < 5; v++) begin
            payload[16*tbl[v].id +: 16] = tbl[v].pay;
            req = '0;
            req[tbl[v].id] = 1'b1;
            check("pre_grant_gnt", gnt, 0);
            tick();
            check("grant_latency", gnt, tbl[v].gnt);
            tick();
            check("grant_pulse_width", gnt, 0);
            wait_idle("table_frame_done", 20);
            check("table_frame_count", frame_log.size(), 1);
            if (frame_log.size() > 0) check("table_frame", frame_log.pop_front(), tbl[v].frame);
        end

        // all four requesting after reset: ID order and one idle cycle between frames
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        gnt_log.delete(); hdr_cyc.delete();
        payload = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b1111;
        wait_idle("all_req_done", 100);
        check("all_req_grants", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) check("all_req_id_order", gnt_log[i], i);
        for (int i = 1; i < 4; i++) check("all_req_frame_spacing", hdr_cyc[i] - hdr_cyc[i-1], 6);

        // back-pressure for 10 cycles while the PH byte is presented
        frame_log.delete();
        payload[31:16] = 16'hBEEF;
        req = 4'b0010;
        tick(); tick(); tick();
        full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_wr_en", wr_en, 0);
            check("stall_data_held", data, 8'hBE);
            tick();
        end
        full = 1'b0;
        @(negedge clk);
        check("stall_release_byte", {wr_en, data}, {1'b1, 8'hBE});
        wait_idle("stall_frame_done", 20);
        check("stall_frame_count", frame_log.size(), 1);
        if (frame_log.size() > 0) check("stall_frame", frame_log.pop_front(), 40'hA501BEEFF5);

        // asynchronous reset while the ID byte is on the bus
        frame_log.delete();
        payload[31:16] = 16'h1357;
        req = 4'b0010;
        tick(); tick();
        check("pre_abort_id_byte", {busy, wr_en, data}, {1'b1, 1'b1, 8'h01});
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {gnt, wr_en, busy, data}, '0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_frame", frame_log.size(), 0);
        gnt_log.delete();
        payload[15:0]  = 16'h0F0F;
        payload[47:32] = 16'h7777;
        req = 4'b0101;
        wait_idle("post_reset_done", 40);
        check("post_reset_first_id", gnt_log[0], 0);
        check("post_reset_second_id", gnt_log[1], 2);
        if (frame_log.size() >= 2) check("post_reset_id2_frame", frame_log[1], 40'hA5027777A7);
        else check("post_reset_frames", frame_log.size(), 2);

        // fairness: REQ[0] held throughout, REQ[2] arrives mid-frame
        gnt_log.delete();
        drop_mask = 4'b1110;
        payload[15:0] = 16'hAAAA;
        req = 4'b0001;
        wait_log("fair_first_grant", 1, 10);
        tick(); tick();
        payload[47:32] = 16'h5555;
        req[2] = 1'b1;
        wait_log("fair_three_grants", 3, 40);
        check("fair_order_0", gnt_log[0], 0);
        check("fair_order_1", gnt_log[1], 2);
        check("fair_order_2", gnt_log[2], 0);
        req = '0;
        drop_mask = '1;
        wait_idle("fair_done", 20);

        // GAP_CYCLES=3 instance
        payload2[15:0]  = 16'hC0DE;
        payload2[31:16] = 16'h0042;
        req2 = 4'b0011;
        collect2(fa, w);
        check("gap_frame0", fa, 40'hA500C0DEBB);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gap_cycle_busy_no_wr", {busy2, wr2}, 2'b10);
        end
        @(negedge clk);
        check("gap_then_idle", busy2, 0);
        req2 = 4'b0010;
        collect2(fb, w);
        req2 = '0;
        check("gap_next_hdr_wait", w, 1);
        check("gap_frame1", fb, 40'hA5010042E6);
        repeat (6) @(negedge clk);
        check("gap_final_idle", busy2, 0);

        // randomized requests and back-pressure against the scoreboard
        tick();
        n_frames  = 0;
        rand_mode = 1;
        repeat (2000) tick();
        rand_mode = 0;
        full = 1'b0;
        wait_idle("rand_drain", 200);
        check("rand_pending_grants", exp_q.size(), 0);
        check("rand_partial_bytes", byte_q.size(), 0);
        check("rand_frames_seen", n_frames > 50, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
